// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational IF lookup, EX-stage training and redirect.
// Optional BP_STATS_EN adds branch and mispredict counters (BrCountO, MissCountO).
module branch_predictor #(
    parameter  int unsigned ENTRIES = 16,
    localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST_N,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic        UpdateE,
    input  logic [31:0] PCE,
    input  logic        BranchTakenE,
    input  logic [31:0] BranchTargetE,
    input  logic        PredTakenE,
    output logic        MispredictE,
    output logic [31:0] RedirectPCE
`ifdef BP_STATS_EN
    ,
    output logic [31:0] BrCountO,
    output logic [31:0] MissCountO
`endif
);

    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    localparam logic [1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] CTR_WEAK_T    = 2'b10;
    localparam logic [1:0] CTR_STRONG_T  = 2'b11;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;

    logic [IDX_W-1:0] e_idx;
    logic [TAG_W-1:0] e_tag;
    logic             e_hit;

    logic             wr_en;
    logic [TAG_W-1:0] wr_tag;
    logic [31:0]      wr_target;
    logic [1:0]       wr_ctr;

    // Byte-offset bits of the PCs never address the table.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

    // Fetch-side lookup reads current state, so a same-cycle write is not visible yet.
    always_comb begin
        f_idx       = PCF[IDX_W+1:2];
        f_tag       = PCF[31:IDX_W+2];
        f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        PredTakenF  = f_hit && ctr_q[f_idx][1];
        PredTargetF = PredTakenF ? target_q[f_idx] : '0;
    end

    always_comb begin
        e_idx     = PCE[IDX_W+1:2];
        e_tag     = PCE[31:IDX_W+2];
        e_hit     = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
        wr_en     = 1'b0;
        wr_tag    = e_tag;
        wr_target = target_q[e_idx];
        wr_ctr    = ctr_q[e_idx];
        if (UpdateE) begin
            if (e_hit) begin
                wr_en = 1'b1;
                if (BranchTakenE) begin
                    wr_target = BranchTargetE;
                    if (ctr_q[e_idx] != CTR_STRONG_T) begin
                        wr_ctr = ctr_q[e_idx] + 2'd1;
                    end
                end else if (ctr_q[e_idx] != CTR_STRONG_NT) begin
                    wr_ctr = ctr_q[e_idx] - 2'd1;
                end
            end else if (BranchTakenE) begin
                wr_en     = 1'b1;
                wr_target = BranchTargetE;
                wr_ctr    = CTR_WEAK_T;
            end
        end
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WEAK_NT;
            end
        end else if (wr_en) begin
            valid_q[e_idx]  <= 1'b1;
            tag_q[e_idx]    <= wr_tag;
            target_q[e_idx] <= wr_target;
            ctr_q[e_idx]    <= wr_ctr;
        end
    end

    always_comb begin
        MispredictE = UpdateE && (PredTakenE != BranchTakenE);
        RedirectPCE = BranchTakenE ? BranchTargetE : (PCE + 32'd4);
    end

`ifdef BP_STATS_EN
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (UpdateE) begin
            br_cnt_d = br_cnt_q + 32'd1;
        end
        if (MispredictE) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign BrCountO   = br_cnt_q;
    assign MissCountO = miss_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor (ENTRIES=16), plus hand sequences for reset and statistics.
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] pcf;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;
    logic        upd;
    logic [31:0] pce;
    logic        taken;
    logic [31:0] tgt;
    logic        pred_e;
    logic        mispred;
    logic [31:0] redirect;
`ifdef BP_STATS_EN
    logic [31:0] br_count;
    logic [31:0] miss_count;
`endif

    int checks   = 0;
    int failures = 0;

    branch_predictor #(.ENTRIES(16)) dut (
        .CPU_CLK       (clk),
        .CPU_RST_N     (rst_n),
        .PCF           (pcf),
        .PredTakenF    (pred_taken_f),
        .PredTargetF   (pred_target_f),
        .UpdateE       (upd),
        .PCE           (pce),
        .BranchTakenE  (taken),
        .BranchTargetE (tgt),
        .PredTakenE    (pred_e),
        .MispredictE   (mispred),
        .RedirectPCE   (redirect)
`ifdef BP_STATS_EN
        ,
        .BrCountO      (br_count),
        .MissCountO    (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pcf;
        logic        upd;
        logic [31:0] pce;
        logic        taken;
        logic [31:0] tgt;
        logic        pred_e;
        logic        exp_pt;
        logic [31:0] exp_ptg;
        logic        exp_mis;
        logic        chk_red;
        logic [31:0] exp_red;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [31:0] f, input logic u, input logic [31:0] e,
                                input logic t, input logic [31:0] g, input logic p,
                                input logic xpt, input logic [31:0] xptg, input logic xmis,
                                input logic cr, input logic [31:0] xred);
        vec_t v;
        v.pcf = f; v.upd = u; v.pce = e; v.taken = t; v.tgt = g; v.pred_e = p;
        v.exp_pt = xpt; v.exp_ptg = xptg; v.exp_mis = xmis; v.chk_red = cr; v.exp_red = xred;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s [%0d]: got 0x%08h expected 0x%08h", name, idx, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        //             pcf           upd pce           tk tgt           pE  pt  ptg           mis cr red
        vecs[0]  = mk(32'h00000040, 1, 32'h00000040, 0, 32'h00000000, 0,  0, 32'h00000000, 0, 1, 32'h00000044);
        vecs[1]  = mk(32'h00000040, 1, 32'h00000040, 1, 32'h00000100, 0,  0, 32'h00000000, 1, 1, 32'h00000100);
        vecs[2]  = mk(32'h00000040, 1, 32'h00000040, 1, 32'h00000100, 1,  1, 32'h00000100, 0, 1, 32'h00000100);
        vecs[3]  = mk(32'h00000040, 1, 32'h00000040, 1, 32'h00000100, 1,  1, 32'h00000100, 0, 1, 32'h00000100);
        vecs[4]  = mk(32'h00000040, 1, 32'h00000040, 0, 32'h00000000, 1,  1, 32'h00000100, 1, 1, 32'h00000044);
        vecs[5]  = mk(32'h00000040, 1, 32'h00000040, 0, 32'h00000000, 1,  1, 32'h00000100, 1, 1, 32'h00000044);
        vecs[6]  = mk(32'h00000040, 1, 32'h00000040, 0, 32'h00000000, 0,  0, 32'h00000000, 0, 1, 32'h00000044);
        vecs[7]  = mk(32'h00000040, 1, 32'h00000040, 0, 32'h00000000, 0,  0, 32'h00000000, 0, 1, 32'h00000044);
        vecs[8]  = mk(32'h00000040, 1, 32'h00000040, 1, 32'h00000100, 0,  0, 32'h00000000, 1, 1, 32'h00000100);
        vecs[9]  = mk(32'h00000040, 0, 32'h00000040, 0, 32'h00000000, 1,  0, 32'h00000000, 0, 0, 32'h00000000);
        vecs[10] = mk(32'h00000040, 1, 32'h00000040, 1, 32'h00000100, 0,  0, 32'h00000000, 1, 1, 32'h00000100);
        vecs[11] = mk(32'h00000040, 0, 32'h00000000, 0, 32'h00000000, 0,  1, 32'h00000100, 0, 0, 32'h00000000);
        vecs[12] = mk(32'h00000040, 0, 32'h00000040, 1, 32'h00000999, 0,  1, 32'h00000100, 0, 0, 32'h00000000);
        vecs[13] = mk(32'h00000040, 0, 32'h00000000, 0, 32'h00000000, 0,  1, 32'h00000100, 0, 0, 32'h00000000);
        vecs[14] = mk(32'h00000080, 1, 32'h00000080, 1, 32'h00000200, 0,  0, 32'h00000000, 1, 1, 32'h00000200);
        vecs[15] = mk(32'h00000040, 0, 32'h00000000, 0, 32'h00000000, 0,  0, 32'h00000000, 0, 0, 32'h00000000);
        vecs[16] = mk(32'h00000080, 1, 32'h000000C0, 0, 32'h00000000, 0,  1, 32'h00000200, 0, 1, 32'h000000C4);
        vecs[17] = mk(32'h00000080, 0, 32'h00000000, 0, 32'h00000000, 0,  1, 32'h00000200, 0, 0, 32'h00000000);
        vecs[18] = mk(32'h00000044, 1, 32'h00000044, 1, 32'h00000400, 0,  0, 32'h00000000, 1, 1, 32'h00000400);
        vecs[19] = mk(32'h00000044, 0, 32'h00000000, 0, 32'h00000000, 0,  1, 32'h00000400, 0, 0, 32'h00000000);
        vecs[20] = mk(32'h00000080, 0, 32'h00000000, 0, 32'h00000000, 0,  1, 32'h00000200, 0, 0, 32'h00000000);
        vecs[21] = mk(32'h00000040, 1, 32'h00000040, 1, 32'h00000100, 0,  0, 32'h00000000, 1, 1, 32'h00000100);
        vecs[22] = mk(32'h00000040, 1, 32'h00000040, 1, 32'h00000300, 1,  1, 32'h00000100, 0, 1, 32'h00000300);
        vecs[23] = mk(32'h00000040, 0, 32'h00000000, 0, 32'h00000000, 0,  1, 32'h00000300, 0, 0, 32'h00000000);
        vecs[24] = mk(32'h00000000, 1, 32'hFFFFFFFC, 0, 32'h00000000, 0,  0, 32'h00000000, 0, 1, 32'h00000000);
        vecs[25] = mk(32'h00000043, 0, 32'h00000000, 0, 32'h00000000, 0,  1, 32'h00000300, 0, 0, 32'h00000000);
        vecs[26] = mk(32'h80000040, 0, 32'h00000000, 0, 32'h00000000, 0,  0, 32'h00000000, 0, 0, 32'h00000000);

        rst_n = 1'b0; pcf = 32'h40; upd = 1'b0; pce = '0; taken = 1'b0; tgt = '0; pred_e = 1'b0;
        #3;
        check("reset_pred_taken", 0, {31'b0, pred_taken_f}, 32'd0);
        check("reset_pred_target", 0, pred_target_f, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            pcf = vecs[i].pcf; upd = vecs[i].upd; pce = vecs[i].pce;
            taken = vecs[i].taken; tgt = vecs[i].tgt; pred_e = vecs[i].pred_e;
            #1;
            check("pred_taken", i, {31'b0, pred_taken_f}, {31'b0, vecs[i].exp_pt});
            check("pred_target", i, pred_target_f, vecs[i].exp_ptg);
            check("mispredict", i, {31'b0, mispred}, {31'b0, vecs[i].exp_mis});
            if (vecs[i].chk_red) check("redirect_pc", i, redirect, vecs[i].exp_red);
        end

        // Asynchronous reset mid-cycle, then a write coincident with reset must be lost.
        @(negedge clk);
        pcf = 32'h40; upd = 1'b0;
        #1;
        check("pre_async_reset_taken", 0, {31'b0, pred_taken_f}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_taken", 0, {31'b0, pred_taken_f}, 32'd0);
        check("async_reset_target", 0, pred_target_f, 32'd0);
        upd = 1'b1; pce = 32'h44; taken = 1'b1; tgt = 32'h400; pred_e = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; upd = 1'b0; pcf = 32'h44;
        #1;
        check("reset_write_lost", 0, {31'b0, pred_taken_f}, 32'd0);
        pcf = 32'h80;
        #1;
        check("reset_cleared_0x80", 0, {31'b0, pred_taken_f}, 32'd0);

`ifdef BP_STATS_EN
        check("stats_reset_br", 0, br_count, 32'd0);
        check("stats_reset_miss", 0, miss_count, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            upd = 1'b1; pce = 32'h1000 + 32'(i) * 4; pred_e = 1'b0;
            taken = (i < 3); tgt = 32'h2000;
        end
        @(negedge clk);
        upd = 1'b0; taken = 1'b0;
        #1;
        check("stats_br_count", 0, br_count, 32'd10);
        check("stats_miss_count", 0, miss_count, 32'd3);
        force dut.br_cnt_q = 32'hFFFFFFFF;
        #1 release dut.br_cnt_q;
        upd = 1'b1; pce = 32'h3000; taken = 1'b0; pred_e = 1'b0;
        @(negedge clk);
        upd = 1'b0;
        #1;
        check("stats_br_wrap", 0, br_count, 32'd0);
        check("stats_miss_hold", 0, miss_count, 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the five-stage RISC-V pipeline: a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry. It produces the predicted next PC. In IF it is looked up combinationally with the fetch PC and hands a predicted-taken flag and target to next-PC selection. In EX it is trained with the resolved conditional-branch outcome and reports mispredictions, together with the corrected PC, to the redirect/flush logic.

## Interface
- ENTRIES, 16: number of BTB entries; power of two, 4..256.
- IDX_W, $clog2(ENTRIES): index width; derived, not overridden.

- CPU_CLK  in  1  pipeline clock; all state updates on rising edge.
- CPU_RST_N  in  1  reset, asynchronous and active-low.
- PCF  in  32  fetch-stage PC.
- PredTakenF  out  1  predicted taken for PCF (combinational).
- PredTargetF  out  32  predicted target for PCF; 0 when PredTakenF=0.
- UpdateE  in  1  EX holds a valid conditional branch this cycle (not stalled, not flushed).
- PCE  in  32  PC of the branch in EX.
- BranchTakenE  in  1  resolved outcome.
- BranchTargetE  in  32  resolved taken target.
- PredTakenE  in  1  PredTakenF value carried down the pipeline with this branch.
- MispredictE  out  1  UpdateE & (PredTakenE != BranchTakenE) (combinational).
- RedirectPCE  out  32  BranchTakenE ? BranchTargetE : PCE+4 (combinational; modulo 2^32).

## Operation
- Entry: valid (1), tag = PC[31:IDX_W+2], target (32), ctr (2). Index = PC[IDX_W+1:2]. PC[1:0] is ignored.
- Lookup: hit = valid & tag match on PCF. PredTakenF = hit & ctr[1]. PredTargetF = target when PredTakenF=1, else 0.
- Update happens on the clock edge when UpdateE=1. Index and tag are taken from PCE.
  - Hit, taken: ctr saturating +1 (max 11); target <= BranchTargetE.
  - Hit, not taken: ctr saturating -1 (min 00); target unchanged.
  - Miss, taken: allocate. valid<=1, tag, target <= BranchTargetE, ctr <= 10 (weakly taken). Any previous occupant is overwritten.
  - Miss, not taken: no state change.
- UpdateE=0: no state change. PCE, BranchTakenE and BranchTargetE are don't-care.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Jal/jalr are not handled by this block. Upstream ensures UpdateE is asserted only for conditional branches.

## Timing
- Lookup has zero latency: PredTakenF/PredTargetF settle from PCF and current state in the same cycle.
- An update written at edge N is visible to lookups from cycle N+1.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update contents.
- MispredictE and RedirectPCE are combinational from the EX inputs. They are valid only while UpdateE=1; MispredictE=0 otherwise.
- Reset (CPU_RST_N low, any time, including mid-update): all valid<=0, all ctr<=01, all target<=0, stats counters <=0. Effect is immediate and asynchronous; outputs read PredTakenF=0, PredTargetF=0. A write at the edge coincident with reset assertion is lost. Release is synchronised externally.

## Configuration
- BP_STATS_EN defined: adds two outputs.
  - BrCountO[31:0]: increments on each cycle with UpdateE=1.
  - MissCountO[31:0]: increments on each cycle with MispredictE=1.
  - Both wrap 0xFFFFFFFF -> 0 and reset to 0.
- BP_STATS_EN undefined: the ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset then lookup: deassert CPU_RST_N, PCF=0x00000040 -> PredTakenF=0, PredTargetF=0; with UpdateE=1, PCE=0x40, BranchTakenE=0, PredTakenE=0 -> MispredictE=0, RedirectPCE=0x44.
- Allocate and train: UpdateE=1, PCE=0x40, taken, target 0x100, PredTakenE=0 -> MispredictE=1, RedirectPCE=0x100. Next cycle PCF=0x40 -> PredTakenF=1, PredTargetF=0x100. Two more taken updates -> ctr=11 (saturates).
- Hysteresis: from ctr=11, one not-taken update -> still PredTakenF=1. Second not-taken -> PredTakenF=0. Third and fourth not-taken -> ctr stays 00.
- Aliasing with ENTRIES=16: train 0x40 taken to 0x100, then update PCE=0x80 taken to 0x200. PCF=0x40 -> miss, PredTakenF=0. PCF=0x80 -> 0x200. A not-taken update at PCE=0xC0 leaves the 0x80 entry intact.
- Same-cycle collision: PCF=0x40 and UpdateE at PCE=0x40 (taken, 0x300) in the same cycle -> lookup shows the old target 0x100; the next cycle shows 0x300. Asserting CPU_RST_N low mid-cycle clears PredTakenF immediately.
- With BP_STATS_EN: 10 updates including 3 mispredicts -> BrCountO=10, MissCountO=3. Preload BrCountO to 0xFFFFFFFF by force, then one update -> 0.
